// File: rtl/disp_pkg.sv
// Shared types and constants for the 4-digit multiplexed 7-segment scan path.
package disp_pkg;

  localparam int           NUM_DIGITS = 4;
  localparam logic [3:0]   AN_OFF     = 4'b1111;
  localparam logic         LE_BLANK   = 1'b1;
  localparam logic         POINT_ON   = 1'b1;

  typedef logic [3:0] digit_t;

  typedef struct packed {
    logic [15:0] hex;
    logic [3:0]  points;
    logic [3:0]  les;
  } disp_t;

  localparam disp_t DISP_RESET = '{hex: 16'h0000, points: 4'h0, les: 4'hF};

  // Active-low anode pattern for one digit; a blanked digit keeps every anode off.
  function automatic logic [3:0] an_for(input logic [1:0] idx, input logic blank);
    logic [3:0] w_onehot;
    w_onehot = 4'b0001 << idx;
    return (blank == LE_BLANK) ? AN_OFF : ~w_onehot;
  endfunction

endpackage

// File: rtl/disp_scan4_prescaler.sv
// Free-running scan prescaler; tick is high while the counter sits at all ones.
module scan_prescaler #(
  parameter int DIV_WIDTH = 17
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  logic [DIV_WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = &r_cnt;

endmodule

// File: rtl/disp_scan4.sv
// Digit scan controller: double-buffered display data, committed only on the 3->0 wrap.
module disp_scan4
  import disp_pkg::*;
#(
  parameter int DIV_WIDTH = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] hexs,
  input  logic [3:0]  points,
  input  logic [3:0]  les,
  input  logic        load,
  output digit_t      hex_out,
  output logic        point_out,
  output logic        le_out,
  output logic [3:0]  AN,
  output logic        frame_done
);

  logic       w_tick;
  logic       w_wrap;
  logic [1:0] w_idx_next;
  disp_t      w_inputs;
  disp_t      w_disp_next;
  logic       w_pending_next;

  logic [1:0] r_idx;
  logic       r_pending;
  disp_t      r_staging;
  disp_t      r_display;

  scan_prescaler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (w_tick)
  );

  assign w_inputs   = '{hex: hexs, points: points, les: les};
  assign w_wrap     = w_tick && (r_idx == 2'(NUM_DIGITS - 1));
  assign w_idx_next = w_tick ? r_idx + 2'd1 : r_idx;

  // A load coinciding with the wrap bypasses staging so it is not held for a full frame.
  always_comb begin
    w_disp_next    = r_display;
    w_pending_next = r_pending;
    if (w_wrap) begin
      if (load) begin
        w_disp_next = w_inputs;
      end else if (r_pending) begin
        w_disp_next = r_staging;
      end
      w_pending_next = 1'b0;
    end else if (load) begin
      w_pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= 2'd0;
      r_pending  <= 1'b0;
      r_staging  <= DISP_RESET;
      r_display  <= DISP_RESET;
      hex_out    <= '0;
      point_out  <= 1'b0;
      le_out     <= LE_BLANK;
      AN         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      r_idx      <= w_idx_next;
      r_pending  <= w_pending_next;
      r_display  <= w_disp_next;
      frame_done <= w_wrap;
      if (load) begin
        r_staging <= w_inputs;
      end
      if (w_tick) begin
        hex_out   <= w_disp_next.hex[{w_idx_next, 2'b00} +: 4];
        point_out <= w_disp_next.points[w_idx_next];
        le_out    <= w_disp_next.les[w_idx_next];
        AN        <= an_for(w_idx_next, w_disp_next.les[w_idx_next]);
      end
    end
  end

endmodule
